mem_stage: RTL and testbench

- MEM stage plus MEM/WB pipeline register of the 5-stage core, directly upstream of the write-back stage.
- Accepts one EX/MEM op per cycle and performs load/store over a req/ack data-memory handshake with wait states, byte-enable generation and store-lane replication.
- Stalls upstream while an access is outstanding and enforces a timeout.
- Produces the registered WB_CTRL/WB_DATA bundle. Load data is passed as the raw word; write-back performs extension.

---
 rtl/mcpu_pkg.sv | 23 ++
 rtl/dm_lane.sv | 27 ++
 rtl/mem_stage.sv | 137 +++++++++++++
 tb/tb_mem_stage.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mcpu_pkg.sv
// Shared definitions for the MEM stage: control/data bundle layouts and the
// access FSM state type.
package mcpu_pkg;
  localparam int MEM_CTRL_W = 7;
  localparam int WB_CTRL_W  = 5;
  localparam int DATA_W     = 69;

  // MEM_CTRL bit positions; the low five bits are also the WB_CTRL layout
  localparam int C_MEMREAD  = 6;
  localparam int C_MEMWRITE = 5;
  localparam int C_REGWRITE = 4;
  localparam int C_MEMTOREG = 3;
  localparam int C_BYTE     = 2;
  localparam int C_HALF     = 1;
  localparam int C_LOADS    = 0;

  // MEM_DATA / WB_DATA field offsets: {rw, EXout, storeData|Dout}
  localparam int D_LO_LSB = 0;
  localparam int D_EX_LSB = 32;
  localparam int D_RW_LSB = 64;

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_e;
endpackage

// File: rtl/dm_lane.sv
// Byte-enable, store-lane replication and alignment check for one access.
module dm_lane (
  input  logic [1:0]  addr_lo,
  input  logic        is_byte,
  input  logic        is_half,
  input  logic [31:0] sd,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic        misalign
);
  // byte takes priority over half when both size flags are set
  always_comb begin
    be       = 4'b1111;
    wdata    = sd;
    misalign = 1'b0;
    if (is_byte) begin
      be    = 4'b0001 << addr_lo;
      wdata = {4{sd[7:0]}};
    end else if (is_half) begin
      be       = addr_lo[1] ? 4'b1100 : 4'b0011;
      wdata    = {2{sd[15:0]}};
      misalign = addr_lo[0];
    end else begin
      misalign = |addr_lo;
    end
  end
endmodule

// File: rtl/mem_stage.sv
// MEM stage with MEM/WB register: runs loads/stores over a req/ack data
// memory port, stalls upstream while an access is outstanding, aborts on timeout.
module mem_stage
  import mcpu_pkg::*;
#(
  parameter int TIMEOUT_CYC = 255,
  parameter int CNT_W       = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  MEM_valid,
  input  logic [MEM_CTRL_W-1:0] MEM_CTRL,
  input  logic [DATA_W-1:0]     MEM_DATA,
  output logic                  o_stall,
  output logic [37:0]           o_MEM_BACK,
  output logic                  dm_req,
  output logic                  dm_we,
  output logic [31:0]           dm_addr,
  output logic [3:0]            dm_be,
  output logic [31:0]           dm_wdata,
  input  logic                  dm_ack,
  input  logic [31:0]           dm_rdata,
  output logic [WB_CTRL_W-1:0]  WB_CTRL,
  output logic [DATA_W-1:0]     WB_DATA,
  output logic                  o_misalign,
  output logic                  o_timeout
);
  logic [4:0]  rw;
  logic [31:0] ex, sd;
  logic        memop, mis, to_hit;
  logic [3:0]  be_c;
  logic [31:0] wdata_c;

  state_e         state, state_n;
  logic [CNT_W-1:0] cnt;
  logic [WB_CTRL_W-1:0] lat_wb;
  logic           lat_we;
  logic [4:0]     lat_rw;
  logic [31:0]    lat_ex;

  assign rw    = MEM_DATA[D_RW_LSB +: 5];
  assign ex    = MEM_DATA[D_EX_LSB +: 32];
  assign sd    = MEM_DATA[D_LO_LSB +: 32];
  assign memop = MEM_valid & (MEM_CTRL[C_MEMREAD] | MEM_CTRL[C_MEMWRITE]);

  assign o_MEM_BACK = {MEM_valid & MEM_CTRL[C_REGWRITE] & ~MEM_CTRL[C_MEMTOREG], ex, rw};

  dm_lane u_lane (
    .addr_lo (ex[1:0]),
    .is_byte (MEM_CTRL[C_BYTE]),
    .is_half (MEM_CTRL[C_HALF]),
    .sd      (sd),
    .be      (be_c),
    .wdata   (wdata_c),
    .misalign(mis)
  );

  // an ack on the last allowed cycle completes the access instead of aborting
  assign to_hit = (cnt == CNT_W'(TIMEOUT_CYC - 1)) & ~dm_ack;

  always_comb begin
    state_n = state;
    o_stall = 1'b0;
    case (state)
      IDLE: if (memop && !mis) begin
        o_stall = 1'b1;
        state_n = BUSY;
      end
      BUSY: if (dm_ack || to_hit) state_n = IDLE;
            else                  o_stall = 1'b1;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= '0;
      dm_req     <= 1'b0;
      dm_we      <= 1'b0;
      dm_addr    <= '0;
      dm_be      <= '0;
      dm_wdata   <= '0;
      WB_CTRL    <= '0;
      WB_DATA    <= '0;
      o_misalign <= 1'b0;
      o_timeout  <= 1'b0;
      lat_wb     <= '0;
      lat_we     <= 1'b0;
      lat_rw     <= '0;
      lat_ex     <= '0;
    end else begin
      state      <= state_n;
      o_misalign <= 1'b0;
      o_timeout  <= 1'b0;
      WB_CTRL    <= '0;
      WB_DATA    <= '0;
      case (state)
        IDLE: begin
          if (memop && !mis) begin
            lat_wb   <= MEM_CTRL[C_REGWRITE:C_LOADS];
            lat_we   <= MEM_CTRL[C_MEMWRITE];
            lat_rw   <= rw;
            lat_ex   <= ex;
            dm_req   <= 1'b1;
            dm_we    <= MEM_CTRL[C_MEMWRITE];
            dm_addr  <= {ex[31:2], 2'b00};
            dm_be    <= be_c;
            dm_wdata <= wdata_c;
            cnt      <= '0;
          end else begin
            // any memop reaching here is misaligned: pass it on without a write
            if (MEM_valid)
              WB_CTRL <= {MEM_CTRL[C_REGWRITE] & ~memop, MEM_CTRL[C_MEMTOREG:C_LOADS]};
            WB_DATA    <= {rw, ex, 32'h0};
            o_misalign <= memop;
          end
        end
        BUSY: begin
          if (dm_ack) begin
            WB_CTRL <= lat_wb;
            WB_DATA <= {lat_rw, lat_ex, lat_we ? 32'h0 : dm_rdata};
            dm_req  <= 1'b0;
          end else if (to_hit) begin
            WB_CTRL   <= {1'b0, lat_wb[C_MEMTOREG:C_LOADS]};
            WB_DATA   <= {lat_rw, lat_ex, 32'h0};
            dm_req    <= 1'b0;
            o_timeout <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed vector table, reset-in-flight sequence and
// randomized ops checked against a transaction-level model.
module tb_mem_stage;
  localparam int TO = 4;

  logic        clk = 1'b0, rst = 1'b0;
  logic        MEM_valid = 1'b0;
  logic [6:0]  MEM_CTRL = '0;
  logic [68:0] MEM_DATA = '0;
  logic        o_stall;
  logic [37:0] o_MEM_BACK;
  logic        dm_req, dm_we;
  logic [31:0] dm_addr, dm_wdata;
  logic [3:0]  dm_be;
  logic        dm_ack = 1'b0;
  logic [31:0] dm_rdata = '0;
  logic [4:0]  WB_CTRL;
  logic [68:0] WB_DATA;
  logic        o_misalign, o_timeout;

  mem_stage #(.TIMEOUT_CYC(TO), .CNT_W(3)) dut (
    .clk(clk), .rst(rst), .MEM_valid(MEM_valid), .MEM_CTRL(MEM_CTRL), .MEM_DATA(MEM_DATA),
    .o_stall(o_stall), .o_MEM_BACK(o_MEM_BACK), .dm_req(dm_req), .dm_we(dm_we),
    .dm_addr(dm_addr), .dm_be(dm_be), .dm_wdata(dm_wdata), .dm_ack(dm_ack),
    .dm_rdata(dm_rdata), .WB_CTRL(WB_CTRL), .WB_DATA(WB_DATA),
    .o_misalign(o_misalign), .o_timeout(o_timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [37:0] back;
    logic [4:0]  wbc;
    logic [68:0] wbd;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        we;
    logic [31:0] addr;
    logic        mis;
    logic        to;
    int          stalls;
    int          reqs;
    int          nonbub;
    logic        idle_ok;
  } obs_t;

  typedef struct {
    logic        v;
    logic [6:0]  ctrl;
    logic [4:0]  rw;
    logic [31:0] ex;
    logic [31:0] sd;
    int          wait_n;   // BUSY cycles without ack before the ack cycle
    logic [31:0] rdata;
    obs_t        exp;
  } vec_t;

  int total = 0, bad = 0;

  task automatic chk(input string nm, input logic [68:0] act, input logic [68:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic cmp(input string tag, input obs_t a, input obs_t e);
    chk({tag, ".back"},   69'(a.back),   69'(e.back));
    chk({tag, ".wbc"},    69'(a.wbc),    69'(e.wbc));
    chk({tag, ".wbd"},    a.wbd,         e.wbd);
    chk({tag, ".be"},     69'(a.be),     69'(e.be));
    chk({tag, ".wdata"},  69'(a.wdata),  69'(e.wdata));
    chk({tag, ".we"},     69'(a.we),     69'(e.we));
    chk({tag, ".addr"},   69'(a.addr),   69'(e.addr));
    chk({tag, ".mis"},    69'(a.mis),    69'(e.mis));
    chk({tag, ".to"},     69'(a.to),     69'(e.to));
    chk({tag, ".stalls"}, 69'(a.stalls), 69'(e.stalls));
    chk({tag, ".reqs"},   69'(a.reqs),   69'(e.reqs));
    chk({tag, ".nonbub"}, 69'(a.nonbub), 69'(e.nonbub));
    chk({tag, ".idle"},   69'(a.idle_ok), 69'(e.idle_ok));
  endtask

  // Transaction-level reference: what one op must look like from outside.
  function automatic obs_t model(input vec_t t);
    obs_t o;
    bit mem, mis, tout;
    int size;
    o = '{default: 0};
    o.idle_ok = 1'b1;
    o.back = {t.v & t.ctrl[4] & ~t.ctrl[3], t.ex, t.rw};
    mem  = t.v && (t.ctrl[6] || t.ctrl[5]);
    size = t.ctrl[2] ? 1 : (t.ctrl[1] ? 2 : 4);
    mis  = mem && (t.ex % size != 0);
    if (!mem || mis) begin
      o.wbc = t.v ? {t.ctrl[4] & ~mis, t.ctrl[3:0]} : 5'd0;
      o.wbd = {t.rw, t.ex, 32'h0};
      o.mis = mis;
    end else begin
      tout     = t.wait_n >= TO;
      o.stalls = 1 + (tout ? TO - 1 : t.wait_n);
      o.reqs   = tout ? TO : t.wait_n + 1;
      o.be     = 4'(((1 << size) - 1) << (t.ex % 4));
      for (int i = 0; i < 4; i++) o.wdata[8*i +: 8] = t.sd[8*(i % size) +: 8];
      o.we     = t.ctrl[5];
      o.addr   = t.ex & ~32'h3;
      o.wbc    = {t.ctrl[4] & ~tout, t.ctrl[3:0]};
      o.wbd    = {t.rw, t.ex, (tout || t.ctrl[5]) ? 32'h0 : t.rdata};
      o.to     = tout;
    end
    return o;
  endfunction

  // Drive one op, play the memory, and record what the DUT did.
  task automatic run_op(input vec_t t, output obs_t o);
    bit done;
    o = '{default: 0};
    @(negedge clk);
    MEM_valid = t.v;
    MEM_CTRL  = t.ctrl;
    MEM_DATA  = {t.rw, t.ex, t.sd};
    dm_ack    = 1'b0;
    dm_rdata  = $urandom;
    #1;
    o.back = o_MEM_BACK;
    if (o_stall) begin
      o.stalls = 1;
      done = 1'b0;
      for (int k = 0; k < TO + 2 && !done; k++) begin
        @(negedge clk);
        if (WB_CTRL != 5'd0) o.nonbub++;
        if (dm_req) begin
          if (o.reqs == 0) begin
            o.be = dm_be; o.wdata = dm_wdata; o.we = dm_we; o.addr = dm_addr;
          end
          o.reqs++;
        end
        dm_ack   = (k == t.wait_n);
        dm_rdata = dm_ack ? t.rdata : $urandom;
        #1;
        if (o_stall) o.stalls++;
        else         done = 1'b1;
      end
      if (!done) o.stalls = 999;
    end
    @(negedge clk);
    o.wbc = WB_CTRL;
    o.wbd = WB_DATA;
    o.mis = o_misalign;
    o.to  = o_timeout;
    if (dm_req) o.reqs++;
    // idle cycle with a stray ack, which must have no effect
    MEM_valid = 1'b0;
    dm_ack    = 1'($urandom_range(0, 1));
    @(negedge clk);
    o.idle_ok = (WB_CTRL == 5'd0) && !o_misalign && !o_timeout && !dm_req;
    dm_ack = 1'b0;
  endtask

  function automatic vec_t mkv(
    input logic v, input logic [6:0] ctrl, input logic [4:0] rw, input logic [31:0] ex,
    input logic [31:0] sd, input int wait_n, input logic [31:0] rdata,
    input logic [37:0] back, input logic [4:0] wbc, input logic [68:0] wbd,
    input logic [3:0] be, input logic [31:0] wdata, input logic we, input logic [31:0] addr,
    input logic mis, input logic to, input int stalls, input int reqs);
    vec_t r;
    r.v = v; r.ctrl = ctrl; r.rw = rw; r.ex = ex; r.sd = sd; r.wait_n = wait_n; r.rdata = rdata;
    r.exp = '{default: 0};
    r.exp.back = back; r.exp.wbc = wbc; r.exp.wbd = wbd; r.exp.be = be; r.exp.wdata = wdata;
    r.exp.we = we; r.exp.addr = addr; r.exp.mis = mis; r.exp.to = to;
    r.exp.stalls = stalls; r.exp.reqs = reqs; r.exp.idle_ok = 1'b1;
    return r;
  endfunction

  vec_t tbl[10];
  vec_t rv;
  obs_t got;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //            v  ctrl        rw  ex         sd            w  rdata
    tbl[0] = mkv(1, 7'b0010000, 5, 32'h1234, 32'h0,        0, 32'h0,
                 {1'b1, 32'h1234, 5'd5}, 5'b10000, {5'd5, 32'h1234, 32'h0},
                 4'h0, 32'h0, 0, 32'h0, 0, 0, 0, 0);
    tbl[1] = mkv(1, 7'b1011101, 7, 32'h103, 32'h12345678, 3, 32'hAABBCCDD,
                 {1'b0, 32'h103, 5'd7}, 5'b11101, {5'd7, 32'h103, 32'hAABBCCDD},
                 4'b1000, 32'h78787878, 0, 32'h100, 0, 0, 4, 4);
    tbl[2] = mkv(1, 7'b0100010, 0, 32'h202, 32'h0000BEEF, 0, 32'h5555AAAA,
                 {1'b0, 32'h202, 5'd0}, 5'b00010, {5'd0, 32'h202, 32'h0},
                 4'b1100, 32'hBEEFBEEF, 1, 32'h200, 0, 0, 1, 1);
    tbl[3] = mkv(1, 7'b1011000, 9, 32'h301, 32'h0,        0, 32'h0,
                 {1'b0, 32'h301, 5'd9}, 5'b01000, {5'd9, 32'h301, 32'h0},
                 4'h0, 32'h0, 0, 32'h0, 1, 0, 0, 0);
    tbl[4] = mkv(1, 7'b1011000, 3, 32'h400, 32'hCAFEF00D, 9, 32'hDEAD0000,
                 {1'b0, 32'h400, 5'd3}, 5'b01000, {5'd3, 32'h400, 32'h0},
                 4'b1111, 32'hCAFEF00D, 0, 32'h400, 0, 1, 4, 4);
    tbl[5] = mkv(1, 7'b1011000, 3, 32'h404, 32'h0,        3, 32'h11223344,
                 {1'b0, 32'h404, 5'd3}, 5'b11000, {5'd3, 32'h404, 32'h11223344},
                 4'b1111, 32'h0, 0, 32'h404, 0, 0, 4, 4);
    tbl[6] = mkv(0, 7'b1111111, 1, 32'h8,   32'hFFFFFFFF, 0, 32'h0,
                 {1'b0, 32'h8, 5'd1}, 5'b00000, {5'd1, 32'h8, 32'h0},
                 4'h0, 32'h0, 0, 32'h0, 0, 0, 0, 0);
    tbl[7] = mkv(1, 7'b0100100, 2, 32'h3,   32'h000000A5, 1, 32'h0,
                 {1'b0, 32'h3, 5'd2}, 5'b00100, {5'd2, 32'h3, 32'h0},
                 4'b1000, 32'hA5A5A5A5, 1, 32'h0, 0, 0, 2, 2);
    tbl[8] = mkv(1, 7'b1110000, 4, 32'h10,  32'h01020304, 0, 32'hFFFF0000,
                 {1'b1, 32'h10, 5'd4}, 5'b10000, {5'd4, 32'h10, 32'h0},
                 4'b1111, 32'h01020304, 1, 32'h10, 0, 0, 1, 1);
    tbl[9] = mkv(1, 7'b1011010, 6, 32'h5,   32'h0,        0, 32'h0,
                 {1'b0, 32'h5, 5'd6}, 5'b01010, {5'd6, 32'h5, 32'h0},
                 4'h0, 32'h0, 0, 32'h0, 1, 0, 0, 0);

    // reset state
    #3;
    chk("rst.dm_req", 69'(dm_req), 69'd0);
    chk("rst.dm_be", 69'(dm_be), 69'd0);
    chk("rst.dm_addr", 69'(dm_addr), 69'd0);
    chk("rst.dm_wdata", 69'(dm_wdata), 69'd0);
    chk("rst.wbc", 69'(WB_CTRL), 69'd0);
    chk("rst.wbd", WB_DATA, 69'd0);
    chk("rst.pulses", 69'({o_misalign, o_timeout, o_stall}), 69'd0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 10; i++) begin
      run_op(tbl[i], got);
      cmp($sformatf("vec%0d", i), got, tbl[i].exp);
    end

    // reset while an access is outstanding
    @(negedge clk);
    MEM_valid = 1'b1;
    MEM_CTRL  = 7'b1011000;
    MEM_DATA  = {5'd1, 32'h500, 32'h0};
    @(negedge clk);
    chk("rstbusy.req_before", 69'(dm_req), 69'd1);
    #2;
    rst = 1'b0;
    MEM_valid = 1'b0;
    #1;
    chk("rstbusy.req", 69'(dm_req), 69'd0);
    chk("rstbusy.wbc", 69'(WB_CTRL), 69'd0);
    chk("rstbusy.stall", 69'(o_stall), 69'd0);
    @(negedge clk);
    rst = 1'b1;
    rv = mkv(1, 7'b1011000, 12, 32'h600, 32'h0, 1, 32'h600D600D,
             '0, '0, '0, '0, '0, 0, '0, 0, 0, 0, 0);
    run_op(rv, got);
    cmp("after_rst", got, model(rv));

    // randomized ops against the reference model
    for (int i = 0; i < 60; i++) begin
      rv = '{default: 0};
      rv.v      = ($urandom_range(0, 9) != 0);
      rv.ctrl   = 7'($urandom);
      rv.rw     = 5'($urandom);
      rv.ex     = $urandom & 32'h0000_0FFF;
      rv.sd     = $urandom;
      rv.wait_n = $urandom_range(0, 5);
      rv.rdata  = $urandom;
      run_op(rv, got);
      cmp($sformatf("rnd%0d", i), got, model(rv));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
